// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared types, opcode/select constants and the state/next-state/output helpers
// for the multicycle MIPS main controller.
package mips_ctrl_pkg;

    localparam int unsigned OP_W    = 6;
    localparam int unsigned ALUOP_W = 2;
    localparam int unsigned SEL_W   = 2;

    typedef enum logic [3:0] {
        RST,
        FETCH,
        DECODE,
        MEMADR,
        MEMRD,
        MEMWB,
        MEMWR,
        RTYPEEX,
        ALUWB,
        BEQEX,
        ADDIEX,
        ORIEX,
        IWB,
        JEX,
        ILLEGAL
    } state_t;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;

    localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
    localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [ALUOP_W-1:0] ALUOP_OR    = 2'b11;

    localparam logic [SEL_W-1:0] SRCB_B     = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_FOUR  = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_IMM   = 2'b10;
    localparam logic [SEL_W-1:0] SRCB_IMMSH = 2'b11;

    localparam logic [SEL_W-1:0] PCSRC_ALU    = 2'b00;
    localparam logic [SEL_W-1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [SEL_W-1:0] PCSRC_JUMP   = 2'b10;

    // Moore part of the control word; fetch_strobe/wr_strobe are later gated by mem_ready.
    typedef struct packed {
        logic               mem_req;
        logic               iord;
        logic               wr_strobe;
        logic               fetch_strobe;
        logic               pcwrite;
        logic               branch;
        logic [SEL_W-1:0]   pcsrc;
        logic               alusrca;
        logic [SEL_W-1:0]   alusrcb;
        logic [ALUOP_W-1:0] aluop;
        logic               regdst;
        logic               memtoreg;
        logic               regwrite;
        logic               illegal_op;
    } ctrl_t;

    function automatic state_t next_state(input state_t s, input logic [OP_W-1:0] op,
                                          input logic rdy);
        state_t n;
        n = RST;
        case (s)
            RST:     n = FETCH;
            FETCH:   n = rdy ? DECODE : FETCH;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: n = MEMADR;
                    OP_RTYPE:     n = RTYPEEX;
                    OP_BEQ:       n = BEQEX;
                    OP_ADDI:      n = ADDIEX;
                    OP_ORI:       n = ORIEX;
                    OP_J:         n = JEX;
                    default:      n = ILLEGAL;
                endcase
            end
            MEMADR:  n = (op == OP_SW) ? MEMWR : MEMRD;
            MEMRD:   n = rdy ? MEMWB : MEMRD;
            MEMWB:   n = FETCH;
            MEMWR:   n = rdy ? FETCH : MEMWR;
            RTYPEEX: n = ALUWB;
            ALUWB:   n = FETCH;
            BEQEX:   n = FETCH;
            ADDIEX:  n = IWB;
            ORIEX:   n = IWB;
            IWB:     n = FETCH;
            JEX:     n = FETCH;
            ILLEGAL: n = FETCH;
            default: n = RST;
        endcase
        return n;
    endfunction

    function automatic ctrl_t state_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.mem_req      = 1'b1;
                c.fetch_strobe = 1'b1;
                c.alusrcb      = SRCB_FOUR;
                c.aluop        = ALUOP_ADD;
                c.pcsrc        = PCSRC_ALU;
            end
            DECODE: begin
                c.alusrcb = SRCB_IMMSH;
                c.aluop   = ALUOP_ADD;
            end
            MEMADR, ADDIEX: begin
                c.alusrca = 1'b1;
                c.alusrcb = SRCB_IMM;
                c.aluop   = ALUOP_ADD;
            end
            ORIEX: begin
                c.alusrca = 1'b1;
                c.alusrcb = SRCB_IMM;
                c.aluop   = ALUOP_OR;
            end
            MEMRD: begin
                c.mem_req = 1'b1;
                c.iord    = 1'b1;
            end
            MEMWR: begin
                c.mem_req   = 1'b1;
                c.iord      = 1'b1;
                c.wr_strobe = 1'b1;
            end
            MEMWB: begin
                c.memtoreg = 1'b1;
                c.regwrite = 1'b1;
            end
            RTYPEEX: begin
                c.alusrca = 1'b1;
                c.alusrcb = SRCB_B;
                c.aluop   = ALUOP_FUNCT;
            end
            ALUWB: begin
                c.regdst   = 1'b1;
                c.regwrite = 1'b1;
            end
            BEQEX: begin
                c.alusrca = 1'b1;
                c.alusrcb = SRCB_B;
                c.aluop   = ALUOP_SUB;
                c.pcsrc   = PCSRC_ALUOUT;
                c.branch  = 1'b1;
            end
            IWB:     c.regwrite   = 1'b1;
            JEX: begin
                c.pcsrc   = PCSRC_JUMP;
                c.pcwrite = 1'b1;
            end
            ILLEGAL: c.illegal_op = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    // An instruction retires on the edge that leaves its final state.
    function automatic logic retires(input state_t s, input logic rdy);
        logic r;
        r = 1'b0;
        case (s)
            MEMWB, ALUWB, IWB, BEQEX, JEX: r = 1'b1;
            MEMWR:                         r = rdy;
            default:                       r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Control bus between the main controller (master) and the multicycle datapath/memory (slave).
interface mips_multicycle_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic [5:0]       op;
    logic             zero;
    logic             mem_ready;
    logic             mem_req;
    logic             iord;
    logic             memwrite;
    logic             irwrite;
    logic             pcwrite;
    logic             branch;
    logic [1:0]       pcsrc;
    logic             alusrca;
    logic [1:0]       alusrcb;
    logic [1:0]       aluop;
    logic             regdst;
    logic             memtoreg;
    logic             regwrite;
    logic             illegal_op;
    logic [CNT_W-1:0] retired;
    logic             pc_en;

    // PC load enable as formed on the datapath side.
    assign pc_en = pcwrite | (branch & zero);

    modport master (
        input  op, zero, mem_ready,
        output mem_req, iord, memwrite, irwrite, pcwrite, branch, pcsrc,
               alusrca, alusrcb, aluop, regdst, memtoreg, regwrite, illegal_op, retired
    );

    modport slave (
        output op, zero, mem_ready,
        input  mem_req, iord, memwrite, irwrite, pcwrite, branch, pcsrc,
               alusrca, alusrcb, aluop, regdst, memtoreg, regwrite, illegal_op, retired,
               pc_en
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS datapath: fetch/decode/execute/memory/writeback
// sequencing with a req/ready memory handshake and a retired-instruction counter.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    mips_multicycle_ctrl_if.master bus
);

    state_t           state;
    state_t           state_nxt;
    ctrl_t            ctl;
    logic [CNT_W-1:0] retired_q;

    assign state_nxt = next_state(state, bus.op, bus.mem_ready);

    // Control word is registered from the next state so outputs come straight off flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= RST;
            ctl       <= '0;
            retired_q <= '0;
        end else begin
            state <= state_nxt;
            ctl   <= state_ctrl(state_nxt);
            if (retires(state, bus.mem_ready)) begin
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    // Only the memory-completion strobes see mem_ready combinationally.
    assign bus.irwrite    = ctl.fetch_strobe & bus.mem_ready;
    assign bus.pcwrite    = ctl.pcwrite | (ctl.fetch_strobe & bus.mem_ready);
    assign bus.memwrite   = ctl.wr_strobe & bus.mem_ready;

    assign bus.mem_req    = ctl.mem_req;
    assign bus.iord       = ctl.iord;
    assign bus.branch     = ctl.branch;
    assign bus.pcsrc      = ctl.pcsrc;
    assign bus.alusrca    = ctl.alusrca;
    assign bus.alusrcb    = ctl.alusrcb;
    assign bus.aluop      = ctl.aluop;
    assign bus.regdst     = ctl.regdst;
    assign bus.memtoreg   = ctl.memtoreg;
    assign bus.regwrite   = ctl.regwrite;
    assign bus.illegal_op = ctl.illegal_op;
    assign bus.retired    = retired_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Cycle-by-cycle vector bench for mips_multicycle_ctrl with a queue-based scoreboard.
module tb_mips_multicycle_ctrl;

    localparam int unsigned CW = 4;

    localparam logic [5:0] T_R    = 6'b000000;
    localparam logic [5:0] T_LW   = 6'b100011;
    localparam logic [5:0] T_SW   = 6'b101011;
    localparam logic [5:0] T_BEQ  = 6'b000100;
    localparam logic [5:0] T_ADDI = 6'b001000;
    localparam logic [5:0] T_ORI  = 6'b001101;
    localparam logic [5:0] T_J    = 6'b000010;
    localparam logic [5:0] T_BAD  = 6'b111111;

    // {mem_req,iord,memwrite,irwrite,pcwrite,branch,pcsrc,alusrca,alusrcb,aluop,regdst,memtoreg,regwrite,illegal_op}
    localparam logic [16:0] C_RST  = 17'b0_0_0_0_0_0_00_0_00_00_0_0_0_0;
    localparam logic [16:0] C_F0   = 17'b1_0_0_0_0_0_00_0_01_00_0_0_0_0;
    localparam logic [16:0] C_F1   = 17'b1_0_0_1_1_0_00_0_01_00_0_0_0_0;
    localparam logic [16:0] C_DEC  = 17'b0_0_0_0_0_0_00_0_11_00_0_0_0_0;
    localparam logic [16:0] C_MADR = 17'b0_0_0_0_0_0_00_1_10_00_0_0_0_0;
    localparam logic [16:0] C_MRD  = 17'b1_1_0_0_0_0_00_0_00_00_0_0_0_0;
    localparam logic [16:0] C_MWB  = 17'b0_0_0_0_0_0_00_0_00_00_0_1_1_0;
    localparam logic [16:0] C_W0   = 17'b1_1_0_0_0_0_00_0_00_00_0_0_0_0;
    localparam logic [16:0] C_W1   = 17'b1_1_1_0_0_0_00_0_00_00_0_0_0_0;
    localparam logic [16:0] C_RTX  = 17'b0_0_0_0_0_0_00_1_00_10_0_0_0_0;
    localparam logic [16:0] C_AWB  = 17'b0_0_0_0_0_0_00_0_00_00_1_0_1_0;
    localparam logic [16:0] C_BEQ  = 17'b0_0_0_0_0_1_01_1_00_01_0_0_0_0;
    localparam logic [16:0] C_ADDI = 17'b0_0_0_0_0_0_00_1_10_00_0_0_0_0;
    localparam logic [16:0] C_ORI  = 17'b0_0_0_0_0_0_00_1_10_11_0_0_0_0;
    localparam logic [16:0] C_IWB  = 17'b0_0_0_0_0_0_00_0_00_00_0_0_1_0;
    localparam logic [16:0] C_JEX  = 17'b0_0_0_0_1_0_10_0_00_00_0_0_0_0;
    localparam logic [16:0] C_ILL  = 17'b0_0_0_0_0_0_00_0_00_00_0_0_0_1;

    logic clk = 1'b0;
    logic reset;

    mips_multicycle_ctrl_if #(.CNT_W(CW)) bus ();

    mips_multicycle_ctrl #(.CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rst;
        logic [5:0]    op;
        logic          rdy;
        logic [16:0]   ctl;
        logic [CW-1:0] ret;
    } vec_t;

    typedef struct {
        logic [16:0]   ctl;
        logic [CW-1:0] ret;
        logic          pc_en;
        int            idx;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    function automatic void add(input logic rst, input logic [5:0] op, input logic rdy,
                                input logic [16:0] ctl, input int ret);
        vec_t v;
        v.rst = rst;
        v.op  = op;
        v.rdy = rdy;
        v.ctl = ctl;
        v.ret = CW'(ret);
        vecs.push_back(v);
    endfunction

    task automatic check_outputs();
        exp_t        e;
        logic [16:0] got;
        e   = sb.pop_front();
        got = {bus.mem_req, bus.iord, bus.memwrite, bus.irwrite, bus.pcwrite, bus.branch,
               bus.pcsrc, bus.alusrca, bus.alusrcb, bus.aluop, bus.regdst, bus.memtoreg,
               bus.regwrite, bus.illegal_op};
        total++;
        if (got !== e.ctl) begin
            bad++;
            $display("FAIL ctl idx=%0d got=%b want=%b", e.idx, got, e.ctl);
        end
        total++;
        if (bus.retired !== e.ret) begin
            bad++;
            $display("FAIL retired idx=%0d got=%0d want=%0d", e.idx, bus.retired, e.ret);
        end
        total++;
        if (bus.pc_en !== e.pc_en) begin
            bad++;
            $display("FAIL pc_en idx=%0d got=%b want=%b", e.idx, bus.pc_en, e.pc_en);
        end
    endtask

    initial begin
        exp_t e;

        // reset and release, then R-type with zero-wait memory
        add(0, T_R, 1, C_RST, 0);
        add(1, T_R, 1, C_RST, 0);
        add(1, T_R, 1, C_F1,  0);
        add(1, T_R, 1, C_DEC, 0);
        add(1, T_R, 1, C_RTX, 0);
        add(1, T_R, 1, C_AWB, 0);
        // lw: two fetch stalls, three read stalls; ready ignored in MEMADR
        add(1, T_LW, 0, C_F0,   1);
        add(1, T_LW, 0, C_F0,   1);
        add(1, T_LW, 1, C_F1,   1);
        add(1, T_LW, 1, C_DEC,  1);
        add(1, T_LW, 0, C_MADR, 1);
        add(1, T_LW, 0, C_MRD,  1);
        add(1, T_LW, 0, C_MRD,  1);
        add(1, T_LW, 0, C_MRD,  1);
        add(1, T_LW, 1, C_MRD,  1);
        add(1, T_LW, 1, C_MWB,  1);
        // sw: ready on the second MEMWR cycle
        add(1, T_SW, 1, C_F1,   2);
        add(1, T_SW, 1, C_DEC,  2);
        add(1, T_SW, 1, C_MADR, 2);
        add(1, T_SW, 0, C_W0,   2);
        add(1, T_SW, 1, C_W1,   2);
        // ori then addi
        add(1, T_ORI,  1, C_F1,   3);
        add(1, T_ORI,  1, C_DEC,  3);
        add(1, T_ORI,  1, C_ORI,  3);
        add(1, T_ORI,  1, C_IWB,  3);
        add(1, T_ADDI, 1, C_F1,   4);
        add(1, T_ADDI, 1, C_DEC,  4);
        add(1, T_ADDI, 1, C_ADDI, 4);
        add(1, T_ADDI, 1, C_IWB,  4);
        // beq then an unknown opcode
        add(1, T_BEQ, 1, C_F1,  5);
        add(1, T_BEQ, 1, C_DEC, 5);
        add(1, T_BEQ, 1, C_BEQ, 5);
        add(1, T_BAD, 1, C_F1,  6);
        add(1, T_BAD, 1, C_DEC, 6);
        add(1, T_BAD, 1, C_ILL, 6);
        // lw abandoned by reset while in MEMRD
        add(1, T_LW, 1, C_F1,   6);
        add(1, T_LW, 1, C_DEC,  6);
        add(1, T_LW, 1, C_MADR, 6);
        add(1, T_LW, 0, C_MRD,  6);
        add(0, T_LW, 0, C_RST,  0);
        add(1, T_LW, 1, C_RST,  0);
        // 16 jumps wrap the 4-bit counter; JEX pcwrite does not need ready
        for (int i = 0; i < 16; i++) begin
            add(1, T_J, 1, C_F1,  i % 16);
            add(1, T_J, 1, C_DEC, i % 16);
            add(1, T_J, 0, C_JEX, i % 16);
        end
        add(1, T_R, 1, C_F1, 0);

        reset         = 1'b0;
        bus.op        = '0;
        bus.mem_ready = 1'b0;
        bus.zero      = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            reset         = vecs[i].rst;
            bus.op        = vecs[i].op;
            bus.mem_ready = vecs[i].rdy;
            bus.zero      = i[0];
            e.ctl   = vecs[i].ctl;
            e.ret   = vecs[i].ret;
            e.pc_en = vecs[i].ctl[12] | (vecs[i].ctl[11] & i[0]);
            e.idx   = i;
            sb.push_back(e);
            @(negedge clk);
            check_outputs();
            @(posedge clk);
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Main control FSM for the multicycle MIPS datapath.
- Sequences fetch, decode, execute, memory and writeback for lw, sw, R-type, beq, addi, ori and j.
- It is the producer of the aluop code consumed by the ALU decoder: aluop 00 add, 01 sub, 10 use funct, 11 or.
- Memory accesses use a req/ready handshake, so fetch and data access can stall.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (0 = in reset)
- op  input  6  opcode field, IR[31:26], valid from DECODE onward
- zero  input  1  ALU zero flag; not used internally, documented for the branch-enable equation
- mem_ready  input  1  memory completes the current access this cycle
- mem_req  output  1  memory access request
- iord  output  1  0 = PC address, 1 = ALU-out address
- memwrite  output  1  memory write strobe
- irwrite  output  1  instruction register load
- pcwrite  output  1  unconditional PC load
- branch  output  1  conditional PC load; the datapath forms pc_en = pcwrite | (branch & zero)
- pcsrc  output  2  00 ALU result, 01 ALU-out, 10 jump target
- alusrca  output  1  0 = PC, 1 = register A
- alusrcb  output  2  00 B, 01 constant 4, 10 sign-extended immediate, 11 immediate shifted left by 2
- aluop  output  2  to the ALU decoder
- regdst  output  1  1 = rd, 0 = rt
- memtoreg  output  1  1 = memory data, 0 = ALU-out
- regwrite  output  1  register file write
- illegal_op  output  1  one-cycle pulse on an unknown opcode
- retired  output  CNT_W  count of completed instructions

Behaviour:
- Moore FSM, except mem_ready qualifies pcwrite, irwrite and memwrite.
- Unlisted outputs are 0; aluop defaults to 00 and alusrcb to 00.
- Reset (reset == 0, asynchronous):
  - state = RST, retired = 0.
  - All outputs are 0 while in RST.
  - RST always goes to FETCH on the next edge.
  - Reset asserted mid-instruction abandons it with no further strobes.
- FETCH: mem_req=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00.
  - pcwrite = irwrite = mem_ready.
  - Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE: alusrca=0, alusrcb=11, aluop=00 (branch target precompute). Next state by op:
  - 100011 (lw) or 101011 (sw) -> MEMADR
  - 000000 (R-type) -> RTYPEEX
  - 000100 (beq) -> BEQEX
  - 001000 (addi) -> ADDIEX
  - 001101 (ori) -> ORIEX
  - 000010 (j) -> JEX
  - anything else -> ILLEGAL
- MEMADR: alusrca=1, alusrcb=10, aluop=00. Go to MEMRD for lw, MEMWR for sw.
- MEMRD: mem_req=1, iord=1. Wait for mem_ready, then MEMWB.
- MEMWB: regdst=0, memtoreg=1, regwrite=1. Then FETCH.
- MEMWR: mem_req=1, iord=1, memwrite=mem_ready. Wait for mem_ready, then FETCH.
- RTYPEEX: alusrca=1, alusrcb=00, aluop=10. Then ALUWB.
- ALUWB: regdst=1, regwrite=1. Then FETCH.
- BEQEX: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1. Then FETCH.
- ADDIEX: alusrca=1, alusrcb=10, aluop=00. Then IWB.
- ORIEX: alusrca=1, alusrcb=10, aluop=11. Then IWB.
- IWB: regdst=0, memtoreg=0, regwrite=1. Then FETCH.
- JEX: pcsrc=10, pcwrite=1. Then FETCH.
- ILLEGAL: illegal_op=1 for exactly one cycle. Then FETCH; retired is not incremented.
- mem_req stays high, with address selection stable, until the cycle mem_ready=1. mem_ready outside FETCH, MEMRD or MEMWR is ignored.
- Latency with zero-wait memory, in cycles:
  - j, beq: 3
  - R-type, addi, ori, sw: 4
  - lw: 5
  - Each cycle of mem_ready=0 adds one cycle.
- retired increments on each edge leaving MEMWB, MEMWR (with mem_ready), ALUWB, IWB, BEQEX or JEX. It wraps modulo 2^CNT_W.

Decomposition:
- Package mips_ctrl_pkg holds:
  - the state enum (RST, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, ALUWB, BEQEX, ADDIEX, ORIEX, IWB, JEX, ILLEGAL)
  - opcode localparams
  - ALUOP_ADD/SUB/FUNCT/OR
  - alusrcb and pcsrc select constants.
- No sub-module. The ALU decoder is instantiated beside this block at the controller top, not inside it.

Test Plan:
- Reset release, mem_ready tied 1, op=000000:
  - states RST, FETCH, DECODE, RTYPEEX, ALUWB, FETCH
  - aluop=10 in RTYPEEX; regwrite=1 and regdst=1 in ALUWB; retired=1.
- lw with mem_ready low for 2 cycles in FETCH and 3 in MEMRD:
  - pcwrite/irwrite pulse exactly once, on the ready cycle; 10 cycles total
  - memtoreg=1 and regwrite=1 in MEMWB.
- sw, mem_ready=1 on the 2nd MEMWR cycle: memwrite is 0 then 1; no regwrite ever; retired +1.
- ori then addi, back to back: aluop=11 in ORIEX and 00 in ADDIEX; both reach IWB with regdst=0; retired +2.
- beq, then op=111111:
  - branch=1, pcsrc=01, aluop=01 in BEQEX
  - ILLEGAL then gives illegal_op=1 for one cycle, retired unchanged, FETCH next.
- Counter and reset edge cases:
  - CNT_W=4 with 16 j instructions: retired wraps from 15 to 0.
  - Reset asserted in MEMRD: outputs go to 0 immediately; after release, flow is RST then FETCH with retired=0.
